// File: rtl/bcd_conv_pkg.sv
// Shared constants and types for the sequential BCD-to-binary setpoint converter.
package bcd_conv_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BIN_W      = 20;
    localparam int OUT_W      = 16;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int WORK_W     = BCD_W + BIN_W;
    localparam int CNT_W      = $clog2(BIN_W + 1);

    localparam logic [OUT_W-1:0] MAX_OUT = 16'hFFFF;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_nibble_adj.sv
// One BCD column of the reverse double-dabble step: subtract 3 when the nibble is 8 or more.
module bcd_nibble_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Six-digit BCD to 16-bit binary converter, one reverse double-dabble iteration per clock,
// with digit validation at accept time and saturation on overflow.
module bcd_to_binary_seq
    import bcd_conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BCD_W-1:0] bcd_in,
    output logic [OUT_W-1:0] volume_ml,
    output logic             done,
    output logic             busy,
    output logic             error
);

    state_t             state;
    logic [WORK_W-1:0]  work;
    logic [CNT_W-1:0]   cnt;
    logic               bad_pend;

    logic [WORK_W-1:0]  shifted;
    logic [BCD_W-1:0]   bcd_adj;
    logic [WORK_W-1:0]  work_nxt;

    assign shifted = work >> 1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .din  (shifted[BIN_W + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign work_nxt = {bcd_adj, shifted[BIN_W-1:0]};

    // An invalid entry reports one cycle after accept; bad_pend carries that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            bad_pend  <= 1'b0;
            volume_ml <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bad_pend) begin
                        bad_pend  <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                        volume_ml <= '0;
                        state     <= DONE;
                    end else if (start) begin
                        error <= 1'b0;
                        cnt   <= '0;
                        work  <= {bcd_in, {BIN_W{1'b0}}};
                        if (has_bad_digit(bcd_in)) begin
                            bad_pend <= 1'b1;
                            state    <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CONV;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CONV: begin
                    if (cnt == CNT_W'(BIN_W)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (|work[BIN_W-1:OUT_W]) begin
                            volume_ml <= MAX_OUT;
                            error     <= 1'b1;
                        end else begin
                            volume_ml <= work[OUT_W-1:0];
                            error     <= 1'b0;
                        end
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized and directed bench for bcd_to_binary_seq against a decimal-arithmetic reference.
module tb_bcd_to_binary_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] bcd_in;
    logic [15:0] volume_ml;
    logic        done;
    logic        busy;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_binary_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bcd_in    (bcd_in),
        .volume_ml (volume_ml),
        .done      (done),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits; {error, volume}.
    function automatic logic [16:0] ref_conv(input logic [23:0] b);
        int val;
        logic [23:0] t;
        t = b;
        val = 0;
        for (int i = 5; i >= 0; i--) begin
            if (t[4*i +: 4] > 4'd9) return {1'b1, 16'h0000};
            val = val * 10 + int'(t[4*i +: 4]);
        end
        if (val > 65535) return {1'b1, 16'hFFFF};
        return {1'b0, val[15:0]};
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Drive start now; it is sampled at the next rising edge (edge k).
    task automatic launch(input logic [23:0] b);
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count edges after k until done; optionally re-pulse start at edge k+inj_at.
    task automatic measure(input int inj_at, input logic [23:0] inj_bcd,
                           output int lat, output int bc);
        bc  = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
            if (lat == inj_at) begin
                start  = 1'b1;
                bcd_in = inj_bcd;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
    endtask

    task automatic run_one(input logic [23:0] b, input string tag, input logic scramble);
        int lat, bc;
        logic [16:0] exp;
        exp = ref_conv(b);
        launch(b);
        if (scramble) bcd_in = 24'($urandom);
        measure(-1, 24'h0, lat, bc);
        chk({tag, "_vol"}, volume_ml, exp[15:0]);
        chk({tag, "_err"}, error, exp[16]);
        chk({tag, "_lat"}, lat, (b[23:20] > 9 || b[19:16] > 9 || b[15:12] > 9 ||
                                 b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9) ? 1 : 21);
        @(posedge clk);
        #1 chk({tag, "_done_1cyc"}, done, 1'b0);
    endtask

    initial begin
        int lat, bc, seen;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vol", volume_ml, 16'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", error, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic conversion with busy window
        launch(24'h001234);
        measure(-1, 24'h0, lat, bc);
        chk("c1234_vol", volume_ml, 16'd1234);
        chk("c1234_err", error, 1'b0);
        chk("c1234_lat", lat, 21);
        chk("c1234_busy", bc, 21);
        chk("c1234_busy_end", busy, 1'b0);
        @(posedge clk);
        #1 chk("c1234_done_1cyc", done, 1'b0);

        run_one(24'h065535, "max", 1'b0);
        run_one(24'h065536, "ovf", 1'b0);
        run_one(24'h999999, "all9", 1'b0);

        // Error is cleared as soon as a valid start is accepted
        launch(24'h000042);
        chk("err_clr_on_start", error, 1'b0);
        measure(-1, 24'h0, lat, bc);
        chk("c42_vol", volume_ml, 16'd42);

        // Invalid digit
        @(negedge clk);
        launch(24'h00A123);
        measure(-1, 24'h0, lat, bc);
        chk("bad_lat", lat, 1);
        chk("bad_err", error, 1'b1);
        chk("bad_vol", volume_ml, 16'h0);
        chk("bad_busy", bc, 0);

        // Start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        launch(24'h000500);
        measure(5, 24'h000999, lat, bc);
        chk("ign_vol", volume_ml, 16'd500);
        chk("ign_lat", lat, 21);
        launch(24'h000999);
        measure(-1, 24'h0, lat, bc);
        chk("b2b_vol", volume_ml, 16'd999);
        chk("b2b_lat", lat, 21);

        // Reset mid-conversion
        @(negedge clk);
        launch(24'h001234);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_vol", volume_ml, 16'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_err", error, 1'b0);
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        run_one(24'h000000, "zero", 1'b0);

        // rst and start together: rst wins
        rst = 1'b1;
        launch(24'h000777);
        rst = 1'b0;
        chk("rst_start_busy", busy, 1'b0);
        @(posedge clk);
        #1 chk("rst_start_done", done, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_one(to_bcd(int'($urandom_range(0, 65535))), "rnd", 1'b1);
        for (int i = 0; i < 60; i++)
            run_one(24'($urandom), "raw", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
